// File: rtl/data_mem_responder_if.sv
// Handshake bundle between the multicycle control unit (master) and the
// data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              dMemRead;
  logic              dMemWrite;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              memDone;
  logic              memBusy;
  logic              memErr;
  logic [2:0]        rspState;

  modport master (
    output dMemRead, dMemWrite, addr, funct3, wdata,
    input  rdata, memDone, memBusy, memErr, rspState
  );

  modport slave (
    input  dMemRead, dMemWrite, addr, funct3, wdata,
    output rdata, memDone, memBusy, memErr, rspState
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures a load/store request, waits WAIT_CYCLES,
// performs a lane access on a word array and returns a one-cycle memDone.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CAPT   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  logic [2:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_f3;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_busy;
  logic              r_mem_err;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_err;
  logic [31:0]       w_word;
  logic [31:0]       w_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wdat;
  logic              w_unused;

  // Upper address bits only alias the array; they never select anything.
  assign w_unused = ^r_addr[ADDR_W-1:IDX_W+2];

  // Error decode works on the captured request, so it is valid from CAPT on.
  always_comb begin
    w_err = 1'b0;
    if (r_f3[1:0] == 2'b01 && r_addr[0])          w_err = 1'b1;
    if (r_f3[1:0] == 2'b10 && r_addr[1:0] != 2'b00) w_err = 1'b1;
    if (r_f3 == 3'b011 || r_f3[2:1] == 2'b11)     w_err = 1'b1;
    if (r_wr && r_f3[2])                          w_err = 1'b1;
  end

  assign w_word  = r_mem[r_idx];
  assign w_shift = w_word >> {r_addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = 32'h0;
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      3'b010:  w_load = w_word;
      default: w_load = 32'h0;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    w_be   = 4'b0000;
    w_wdat = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wdat = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be   = 4'b1111;
        w_wdat = r_wdata;
      end
      default: begin
        w_be   = 4'b0000;
        w_wdat = r_wdata;
      end
    endcase
  end

  // The array is not reset, but a reset edge must never commit a store.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_ACCESS && r_wr && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][b*8 +: 8] <= w_wdat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_f3      <= 3'd0;
      r_wdata   <= 32'h0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_rdata   <= 32'h0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.dMemRead || bus.dMemWrite) begin
            r_wr    <= bus.dMemWrite;
            r_addr  <= bus.addr;
            r_f3    <= bus.funct3;
            r_wdata <= bus.wdata;
            r_busy  <= 1'b1;
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_err   <= w_err;
          r_idx   <= r_addr[IDX_W+1:2];
          r_cnt   <= WAIT_LD;
          r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_ACCESS;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          r_done    <= 1'b1;
          r_mem_err <= r_err;
          if (!r_wr) r_rdata <= r_err ? 32'h0 : w_load;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_done  <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          // Held level strobes must drop before another request is taken.
          if (!bus.dMemRead && !bus.dMemWrite) begin
            r_busy    <= 1'b0;
            r_mem_err <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.memDone  = r_done;
  assign bus.memBusy  = r_busy;
  assign bus.memErr   = r_mem_err;
  assign bus.rspState = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 4, 0) checked
// against a byte-level memory model, directed cases then random traffic.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       rd, wr;
  logic [2:0][31:0] addr, wdata;
  logic [2:0][2:0]  f3;
  wire  [2:0][31:0] rdata;
  wire  [2:0]       done, busy, err;
  wire  [2:0][2:0]  st;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder_if #(.ADDR_W(32)) bus ();
    assign bus.dMemRead  = rd[g];
    assign bus.dMemWrite = wr[g];
    assign bus.addr      = addr[g];
    assign bus.funct3    = f3[g];
    assign bus.wdata     = wdata[g];
    assign rdata[g]      = bus.rdata;
    assign done[g]       = bus.memDone;
    assign busy[g]       = bus.memBusy;
    assign err[g]        = bus.memErr;
    assign st[g]         = bus.rspState;
    data_mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 4 : 0)),
      .ADDR_W(32)
    ) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
    );
  end

  int          wc [3] = '{1, 4, 0};
  logic [31:0] m_mem [3][1024];
  logic [31:0] m_rdata [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_err(input bit is_wr, input logic [2:0] f, input logic [31:0] a);
    if (is_wr && f > 3'd2) return 1'b1;
    if (!is_wr && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
    return (a % acc_size(f)) != 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] m_load(input int i, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w, b, h;
    int off;
    w   = m_mem[i][widx(a)];
    off = int'(a % 4);
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (8 * ((off / 2) * 2))) & 32'hFFFF;
    case (f)
      3'd0: return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      3'd2: return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input int i, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w;
    int off;
    w   = m_mem[i][widx(a)];
    off = int'(a % 4);
    for (int k = 0; k < acc_size(f); k++) w[(off + k) * 8 +: 8] = d[k * 8 +: 8];
    m_mem[i][widx(a)] = w;
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, " st"},   32'(st[i]),   32'd0);
    chk({tag, " busy"}, 32'(busy[i]), 32'd0);
    chk({tag, " err"},  32'(err[i]),  32'd0);
    chk({tag, " done"}, 32'(done[i]), 32'd0);
  endtask

  // One full transaction: drive, scramble inputs after capture, find memDone,
  // check response, stay in HOLD for hold_n cycles, release, check idle.
  task automatic op(input int i, input bit do_rd, input bit do_wr, input logic [31:0] a,
                    input logic [2:0] f, input logic [31:0] d, input int hold_n, input string tag);
    logic        e_err;
    logic [31:0] e_rdata;
    int          k;
    bit          seen;
    e_err   = m_err(do_wr, f, a);
    e_rdata = do_wr ? m_rdata[i] : (e_err ? 32'h0 : m_load(i, a, f));
    @(negedge clk);
    rd[i] = do_rd; wr[i] = do_wr; addr[i] = a; f3[i] = f; wdata[i] = d;
    @(posedge clk);
    #1;
    addr[i] = $urandom; f3[i] = 3'($urandom); wdata[i] = $urandom;
    k = 0; seen = 0;
    while (k < 40 && !seen) begin
      @(posedge clk);
      #1;
      k++;
      if (done[i]) seen = 1;
    end
    chk({tag, " latency"}, 32'(k), 32'(wc[i] + 2));
    chk({tag, " err"},     32'(err[i]), 32'(e_err));
    chk({tag, " rdata"},   rdata[i], e_rdata);
    chk({tag, " busy"},    32'(busy[i]), 32'd1);
    if (do_wr && !e_err) m_store(i, a, f, d);
    m_rdata[i] = e_rdata;
    for (int h = 0; h < hold_n; h++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold done"}, 32'(done[i]), 32'd0);
      chk({tag, " hold st"},   32'(st[i]),   32'd5);
      chk({tag, " hold busy"}, 32'(busy[i]), 32'd1);
    end
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(posedge clk);
    #1;
    chk_idle(i, {tag, " release"});
  endtask

  // Store request aborted by reset after `edges` cycles beyond the sampling edge.
  task automatic rst_abort(input int i, input logic [31:0] a, input logic [31:0] d,
                           input int edges, input logic [2:0] exp_st, input string tag);
    @(negedge clk);
    wr[i] = 1'b1; rd[i] = 1'b0; addr[i] = a; f3[i] = 3'd2; wdata[i] = d;
    @(posedge clk);
    repeat (edges) @(posedge clk);
    #1;
    chk({tag, " pre st"}, 32'(st[i]), 32'(exp_st));
    rst[i] = 1'b1; wr[i] = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " rdata"}, rdata[i], 32'h0);
    chk_idle(i, {tag, " rst"});
    m_rdata[i] = 32'h0;
    @(negedge clk);
    rst[i] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk({tag, " no done"}, 32'(done[i]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int kind;
    rst = '1; rd = '0; wr = '0; addr = '0; f3 = '0; wdata = '0;
    for (int i = 0; i < 3; i++) m_rdata[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset rdata", rdata[i], 32'h0);
      chk_idle(i, "reset");
    end
    @(negedge clk);
    rst = '0;

    // WAIT_CYCLES=1: word, byte, half lanes and errors
    op(0, 0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 1, "SW 10");
    op(0, 1, 0, 32'h10, 3'd2, 32'h0,        1, "LW 10");
    op(0, 0, 1, 32'h12, 3'd0, 32'h000000A5, 1, "SB 12");
    op(0, 1, 0, 32'h10, 3'd2, 32'h0,        1, "LW 10 after SB");
    op(0, 1, 0, 32'h12, 3'd0, 32'h0,        1, "LB 12");
    op(0, 1, 0, 32'h12, 3'd4, 32'h0,        1, "LBU 12");
    op(0, 1, 0, 32'h12, 3'd1, 32'h0,        1, "LH 12");
    op(0, 1, 0, 32'h10, 3'd5, 32'h0,        1, "LHU 10");
    op(0, 1, 0, 32'h11, 3'd2, 32'h0,        1, "LW 11 misaligned");
    op(0, 0, 1, 32'h13, 3'd1, 32'h1234,     1, "SH 13 misaligned");
    op(0, 1, 0, 32'h10, 3'd2, 32'h0,        1, "LW 10 after bad SH");
    op(0, 1, 0, 32'h10, 3'd3, 32'h0,        1, "load f3=011");
    op(0, 0, 1, 32'h10, 3'd4, 32'hFFFFFFFF, 1, "store f3=100");
    op(0, 1, 0, 32'h10, 3'd2, 32'h0,        5, "LW hold 5");
    op(0, 1, 1, 32'h20, 3'd2, 32'h55,       1, "RD+WR 20");
    op(0, 1, 0, 32'h20, 3'd2, 32'h0,        1, "LW 20");

    // random traffic over a preloaded window
    for (int n = 0; n < 8; n++) op(0, 0, 1, 32'h100 + 32'(4 * n), 3'd2, $urandom, 1, "rnd init");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      op(0, kind != 1, kind != 0, 32'h100 + 32'($urandom_range(0, 31)), 3'($urandom),
         $urandom, $urandom_range(1, 3), "rnd");
    end

    // WAIT_CYCLES=4: reset during WAIT and at the ACCESS edge
    op(1, 0, 1, 32'h30, 3'd2, 32'h0BADC0DE, 1, "SW 30");
    rst_abort(1, 32'h30, 32'h11111111, 2, 3'd2, "rst in WAIT");
    op(1, 1, 0, 32'h30, 3'd2, 32'h0, 1, "LW 30 after WAIT rst");
    rst_abort(1, 32'h30, 32'h22222222, 5, 3'd3, "rst at ACCESS");
    op(1, 1, 0, 32'h30, 3'd2, 32'h0, 1, "LW 30 after ACCESS rst");

    // WAIT_CYCLES=0: aliasing
    op(2, 0, 1, 32'h1000, 3'd2, 32'hCAFEF00D, 1, "SW 1000");
    op(2, 1, 0, 32'h0,    3'd2, 32'h0,        1, "LW 0 alias");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
